fpu_issue: RTL

//  Sequencer directly upstream of the FPU: accepts one FP op from the core, latches operands,

---
 rtl/fpu_issue_if.sv | 38 +++
 rtl/fpu_issue.sv | 120 ++++++++++++
 2 files changed

// File: rtl/fpu_issue_if.sv
// Bundle of the core-side issue/writeback signals and the FPU-side operand/result
// signals around the FPU issue sequencer. The master side is the core plus FPU
// environment; the slave side is the sequencer itself.
interface fpu_issue_if;
  // core -> sequencer
  logic        issue;
  logic        flush;
  logic [3:0]  op;
  logic        op_mode;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [5:0]  rd;
  // sequencer -> FPU
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic [3:0]  fpucontrol;
  logic        mode;
  logic        fpu_go;
  // FPU -> sequencer
  logic [31:0] fpu_c;
  logic        fpu_valid;
  // sequencer -> core
  logic        stall;
  logic        wb_en;
  logic [5:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err;

  modport master (
    output issue, flush, op, op_mode, src_a, src_b, rd, fpu_c, fpu_valid,
    input  fpu_a, fpu_b, fpucontrol, mode, fpu_go, stall, wb_en, wb_rd, wb_data, err
  );

  modport slave (
    input  issue, flush, op, op_mode, src_a, src_b, rd, fpu_c, fpu_valid,
    output fpu_a, fpu_b, fpucontrol, mode, fpu_go, stall, wb_en, wb_rd, wb_data, err
  );
endinterface

// File: rtl/fpu_issue.sv
// FPU issue sequencer: accepts one FP op at a time from the core, holds the
// operands steady for the FPU, pulses fpu_go, waits (bounded) for fpu_valid and
// returns the result as a one-cycle writeback. Illegal ops and timeouts write
// back zero and set a sticky error flag.
module fpu_issue #(
  parameter int TIMEOUT = 256,
  parameter int NUM_OPS = 10
) (
  input  logic      clk,
  input  logic      rstn,
  fpu_issue_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_W = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [4:0]    NUM_OPS_W = 5'(NUM_OPS);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LAUNCH = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_fpu_a;
  logic [31:0]   r_fpu_b;
  logic [3:0]    r_ctrl;
  logic          r_mode;
  logic [5:0]    r_tag;
  logic [31:0]   r_wb_data;
  logic          r_err;

  logic          w_legal;
  logic [CW-1:0] w_cnt_inc;
  logic          w_busy;

  assign w_legal   = ({1'b0, bus.op} < NUM_OPS_W);
  assign w_cnt_inc = r_cnt + CNT_ONE;
  assign w_busy    = (r_state == LAUNCH) || (r_state == WAIT);

  // Sequencer FSM, operand latch, result capture and sticky error.
  // Flush has top priority: it beats a simultaneous issue and fpu_valid.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_fpu_a   <= '0;
      r_fpu_b   <= '0;
      r_ctrl    <= '0;
      r_mode    <= 1'b0;
      r_tag     <= '0;
      r_wb_data <= '0;
      r_err     <= 1'b0;
    end else if (bus.flush) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.issue) begin
            r_fpu_a   <= bus.src_a;
            r_fpu_b   <= bus.src_b;
            r_ctrl    <= bus.op;
            r_mode    <= bus.op_mode;
            r_tag     <= bus.rd;
            r_wb_data <= '0;
            r_cnt     <= '0;
            if (w_legal) begin
              r_state <= LAUNCH;
            end else begin
              // Illegal op never reaches the FPU; write back zero.
              r_state <= DONE;
              r_err   <= 1'b1;
            end
          end
        end
        LAUNCH: begin
          // Any fpu_valid seen here belongs to an older op and is ignored.
          r_state <= WAIT;
        end
        WAIT: begin
          if (bus.fpu_valid) begin
            r_wb_data <= bus.fpu_c;
            r_cnt     <= '0;
            r_state   <= DONE;
          end else if (w_cnt_inc == TIMEOUT_W) begin
            // Abort after TIMEOUT silent WAIT cycles.
            r_wb_data <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b1;
            r_state   <= DONE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.fpu_a      = r_fpu_a;
  assign bus.fpu_b      = r_fpu_b;
  assign bus.fpucontrol = r_ctrl;
  assign bus.mode       = r_mode;
  // A flush in LAUNCH still lets the pulse out; its result is simply discarded.
  assign bus.fpu_go     = (r_state == LAUNCH);
  // Stall is forced low while reset is held so the core sees a quiet sequencer.
  assign bus.stall      = rstn & (w_busy | ((r_state == IDLE) & bus.issue & ~bus.flush));
  assign bus.wb_en      = (r_state == DONE) & ~bus.flush;
  assign bus.wb_rd      = r_tag;
  assign bus.wb_data    = r_wb_data;
  assign bus.err        = r_err;

endmodule
